// File: rtl/enum_arb_pkg.sv
// Shared types for the enum-coded round-robin arbiter.
// Grant encoding, FSM states and the grant-to-request decode.
package enum_arb_pkg;

    typedef enum logic [2:0] {
        GNT_NONE = 3'h0,
        GNT_X    = 3'h1,
        GNT_Y    = 3'h2,
        GNT_Z    = 3'h3
    } gnt_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } st_e;

    function automatic logic [2:0] gnt_onehot(input gnt_e g);
        logic [2:0] oh;
        oh = 3'b000;
        case (g)
            GNT_X:   oh = 3'b001;
            GNT_Y:   oh = 3'b010;
            GNT_Z:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/enum_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: scans cyclically starting
// from the requester after last_i; GNT_NONE when nobody requests.
module rr_pick
    import enum_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  gnt_e       last_i,
    output gnt_e       pick_o
);

    always_comb begin
        pick_o = GNT_NONE;
        case (last_i)
            GNT_X: begin
                if      (req_i[1]) pick_o = GNT_Y;
                else if (req_i[2]) pick_o = GNT_Z;
                else if (req_i[0]) pick_o = GNT_X;
            end
            GNT_Y: begin
                if      (req_i[2]) pick_o = GNT_Z;
                else if (req_i[0]) pick_o = GNT_X;
                else if (req_i[1]) pick_o = GNT_Y;
            end
            default: begin
                if      (req_i[0]) pick_o = GNT_X;
                else if (req_i[1]) pick_o = GNT_Y;
                else if (req_i[2]) pick_o = GNT_Z;
            end
        endcase
    end

endmodule

// File: rtl/enum_rr_arbiter.sv
// Three-way round-robin arbiter: grant, hold, one-cycle release gap.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module enum_rr_arbiter
    import enum_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output gnt_e       gnt,
    output logic       gnt_vld,
    output logic       timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX must be in 1..255");
    end

    st_e  st_q, st_d;
    gnt_e gnt_q, gnt_d;
    gnt_e last_q, last_d;
    logic vld_q, vld_d;
    gnt_e pick;

    rr_pick u_pick (
        .req_i  (req),
        .last_i (last_q),
        .pick_o (pick)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CntLast = CW'(HOLD_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        st_d   = st_q;
        gnt_d  = gnt_q;
        last_d = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d  = cnt_q;
        to_d   = 1'b0;
`endif
        case (st_q)
            IDLE: begin
                if (pick != GNT_NONE) begin
                    st_d   = GRANT;
                    gnt_d  = pick;
                    last_d = pick;
`ifdef ARB_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                end
            end
            GRANT: begin
                // An owner dropping its request wins over a timeout
                if ((req & gnt_onehot(gnt_q)) == 3'b000) begin
                    st_d  = RELEASE;
                    gnt_d = GNT_NONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    st_d  = RELEASE;
                    gnt_d = GNT_NONE;
                    to_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                st_d  = IDLE;
                gnt_d = GNT_NONE;
            end
            default: begin
                st_d  = IDLE;
                gnt_d = GNT_NONE;
            end
        endcase
        vld_d = (gnt_d != GNT_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            gnt_q  <= GNT_NONE;
            last_q <= GNT_Z;
            vld_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            gnt_q  <= gnt_d;
            last_q <= last_d;
            vld_q  <= vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_vld = vld_q;

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Scoreboard bench for enum_rr_arbiter: stimulus queues expected
// grant starts / timeouts, a negedge monitor pops and compares.
module tb_enum_rr_arbiter;
    import enum_arb_pkg::*;

    typedef struct {
        gnt_e g;
        int   gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    gnt_e       gnt;
    logic       gnt_vld;
    logic       timeout;
    logic       rst_d = 1'b1;
    bit         stim_done = 1'b0;

    exp_t exp_q[$];
    gnt_e to_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    enum_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_d <= rst;

    function automatic void chk(string nm, bit ok, int act, int exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        gnt_e prev;
        int   none_run;
        exp_t e;
        gnt_e to_exp;
        prev = GNT_NONE;
        none_run = 0;
        forever begin
            @(negedge clk);
            if (stim_done) begin
                chk("grants_left", exp_q.size() == 0, exp_q.size(), 0);
                chk("timeouts_left", to_q.size() == 0, to_q.size(), 0);
                $display("%0d/%0d checks passed", n_pass, n_tot);
                $finish;
            end
            if (rst_d)
                chk("reset", {gnt, gnt_vld, timeout} == 5'd0,
                    int'({gnt, gnt_vld, timeout}), 0);
            chk("vld", gnt_vld == (gnt != GNT_NONE), gnt_vld, gnt != GNT_NONE);
            if (timeout) begin
                if (to_q.size() == 0) begin
                    chk("timeout_unexpected", 1'b0, 1, 0);
                end else begin
                    to_exp = to_q.pop_front();
                    chk("timeout_owner", prev == to_exp, prev, to_exp);
                    chk("timeout_gnt", gnt == GNT_NONE, gnt, GNT_NONE);
                end
            end
            if (gnt == GNT_NONE) begin
                none_run++;
            end else if (prev != GNT_NONE) begin
                chk("hold", gnt == prev, gnt, prev);
            end else begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", 1'b0, gnt, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", gnt == e.g, gnt, e.g);
                    if (e.gap >= 0)
                        chk("gap", none_run == e.gap, none_run, e.gap);
                end
                none_run = 0;
            end
            prev = gnt;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    // Stimulus; inputs change 1 time unit after each rising edge
    initial begin
        rst = 1'b1;
        req = 3'b111;
        tick(2);
        rst = 1'b0;
        exp_q.push_back('{GNT_X, -1});
        exp_q.push_back('{GNT_Y, 2});
        exp_q.push_back('{GNT_Z, 2});
        exp_q.push_back('{GNT_X, 2});
        tick(1);

        // Rotation: each owner holds 2 cycles then drops for one
        for (int i = 0; i < 3; i++) begin
            tick(1);
            req[i] = 1'b0;
            tick(1);
            req[i] = 1'b1;
            tick(2);
        end

        // Lone requester Z, re-granted repeatedly
        exp_q.push_back('{GNT_Z, 2});
        req = 3'b100;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{GNT_Z, 2});
            tick(1);
            req = 3'b000;
            tick(1);
            req = 3'b100;
            tick(2);
        end

        // Hand over Z -> X -> Y, then X also requests while Y holds
        exp_q.push_back('{GNT_X, 2});
        req = 3'b001;
        tick(3);
        exp_q.push_back('{GNT_Y, 2});
        req = 3'b010;
        tick(3);
        req = 3'b011;
`ifdef ARB_TIMEOUT_EN
        to_q.push_back(GNT_Y);
        exp_q.push_back('{GNT_X, 2});
        tick(6);
`else
        tick(100);
        exp_q.push_back('{GNT_X, 2});
        req = 3'b001;
        tick(3);
`endif
        req = 3'b000;
        tick(3);

        // Mid-grant reset: last returns to Z so X wins again
        exp_q.push_back('{GNT_X, -1});
        exp_q.push_back('{GNT_X, -1});
        req = 3'b001;
        tick(1);
        rst = 1'b1;
        req = 3'b111;
        tick(1);
        rst = 1'b0;
        tick(1);
        req = 3'b000;
        tick(4);
        stim_done = 1'b1;
    end

endmodule
